gate_edge_monitor: RTL and testbench
====================================

GATE_EDGE_MONITOR -- requirements
Module: gate_edge_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, consecutive differing samples needed to accept a level change (legal range 1..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port a_in  input  1  AND-gate output of the upstream gate stage, asynchronous to clk.
REQ-006 SHALL have port a1_in  input  1  OR-gate output of the upstream gate stage, asynchronous to clk.
REQ-007 SHALL have port a_filt  output  1  debounced level of a_in.
REQ-008 SHALL have port a1_filt  output  1  debounced level of a1_in.
REQ-009 SHALL have port evt_valid  output  1  FIFO non-empty; head event presented.
REQ-010 SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-011 SHALL have port evt_data  output  2  head event, {chan, level}; chan 0 = a, 1 = a1.
REQ-012 SHALL have port ovf  output  1  sticky flag: event dropped because FIFO lacked space.
REQ-013 SHALL have port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-014 SHALL pass each input through a two-flop synchronizer before any other use.
REQ-015 SHALL run one filter FSM per channel, states STABLE and PENDING, with a counter of width 4.
REQ-016 STABLE: sync == filt -> stay, counter 0; sync != filt -> PENDING, counter 1.
REQ-017 PENDING: sync == filt -> STABLE, counter 0 (glitch rejected, no event); sync != filt and counter == STABLE_CYCLES -> toggle filt, emit event, return to STABLE, counter 0; else counter +1.
REQ-018 SHALL make filt change exactly STABLE_CYCLES+2 rising edges after the edge that first samples a new stable input level.
REQ-019 SHALL push event {chan, new filt level} into the FIFO in the same cycle filt changes.
REQ-020 SHALL accept up to two pushes per cycle; on simultaneous events, chan 0 is ordered ahead of chan 1.
REQ-021 SHALL compute push space as free entries plus one if a pop occurs in that same cycle.
REQ-022 Insufficient space: SHALL write chan 0 first if one slot remains, drop the remainder, and set ovf the next cycle.
REQ-023 SHALL pop when evt_valid && evt_ready; evt_data stays stable while evt_valid && !evt_ready.
REQ-024 SHALL keep evt_valid low while the FIFO is empty; a pushed event appears on evt_data one cycle after the push, with no bypass.
REQ-025 ovf_clr SHALL clear ovf unless a new drop occurs in the same cycle, in which case ovf stays 1.
REQ-026 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.

Reset
REQ-027 On rst_n low, SHALL immediately clear synchronizers, filt outputs (0), FSMs (STABLE), counters, FIFO (empty, evt_valid 0, evt_data 0) and ovf.
REQ-028 Reset asserted mid-operation SHALL discard pending filter counts and queued events; no event SHALL be generated on reset release.

Structure
REQ-029 SHALL place the following in package gate_edge_monitor_pkg: evt_t struct {chan, level}, chan enum CH_A=0/CH_A1=1, filter state enum.
REQ-030 SHALL implement the filter FSM as sub-module gate_debounce, instantiated once per channel; the FIFO stays inline.

Verification
REQ-031 STABLE_CYCLES=4, a_in 0->1 held: a_filt rises 6 edges after the first sampling edge; one event {0,1}; evt_valid asserts the next cycle.
REQ-032 a1_in 1-cycle and 3-cycle pulses (STABLE_CYCLES=4): a1_filt stays 0; no events; FSM returns to STABLE.
REQ-033 a_in and a1_in rise in the same cycle: events pop in order {0,1} then {1,1}.
REQ-034 evt_ready=0, 6 edges generated, FIFO_DEPTH=4: 4 events retained in order, ovf=1; ovf_clr pulse -> ovf=0; draining 4 pops empties the FIFO.
REQ-035 FIFO full with pop and two simultaneous events in the same cycle: chan 0 event stored, chan 1 event dropped, ovf=1.
REQ-036 rst_n pulsed low with 3 events queued and a filter PENDING: evt_valid=0 and filts=0 immediately; no events after release.

Source files
------------

// File: rtl/gate_edge_monitor_pkg.sv
// ============================================================================
// gate_edge_monitor_pkg -- shared types for the gate edge monitor.  Rev 1.0
// ============================================================================
`default_nettype none

package gate_edge_monitor_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    CH_A  = 1'b0,
    CH_A1 = 1'b1
  } chan_t;

  typedef struct packed {
    chan_t chan;
    logic  level;
  } evt_t;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } filt_state_t;

  function automatic evt_t make_evt(input chan_t chan, input logic level);
    evt_t e;
    e.chan  = chan;
    e.level = level;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gate_edge_monitor_debounce.sv
// ============================================================================
// gate_debounce -- 2-flop synchronizer plus STABLE/PENDING level filter.  Rev 1.0
// ============================================================================
`default_nettype none

module gate_debounce
  import gate_edge_monitor_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic filt,
  output logic evt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic              sync1;
  logic              sync2;
  filt_state_t       state;
  filt_state_t       state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              filt_nxt;
  logic              evt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= ST_STABLE;
      cnt   <= '0;
      filt  <= 1'b0;
      evt   <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      filt  <= filt_nxt;
      evt   <= evt_nxt;
    end
  end

  // evt is registered alongside filt so the push lands in the cycle filt shows its new level
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    filt_nxt  = filt;
    evt_nxt   = 1'b0;
    case (state)
      ST_STABLE: begin
        if (sync2 != filt) begin
          state_nxt = ST_PENDING;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      ST_PENDING: begin
        if (sync2 == filt) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
          filt_nxt  = ~filt;
          evt_nxt   = 1'b1;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/gate_edge_monitor.sv
// ============================================================================
// gate_edge_monitor -- debounces two gate outputs and queues their edges.  Rev 1.0
// ============================================================================
`default_nettype none

module gate_edge_monitor
  import gate_edge_monitor_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_in,
  input  logic       a1_in,
  output logic       a_filt,
  output logic       a1_filt,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_data,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              SW      = AW + 2;
  localparam logic [SW-1:0]   DEPTH_W = SW'(FIFO_DEPTH);

  logic a_evt;
  logic a1_evt;

  gate_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (a_in),
    .filt  (a_filt),
    .evt   (a_evt)
  );

  gate_debounce #(.STABLE_CYCLES(STABLE_CYCLES)) u_deb_a1 (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (a1_in),
    .filt  (a1_filt),
    .evt   (a1_evt)
  );

  evt_t            mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     used;
  logic [SW-1:0]   space;
  logic [SW-1:0]   need;
  logic            pop;
  logic            slot0_en;
  logic            slot1_en;
  logic            drop;
  evt_t            slot0_data;
  evt_t            slot1_data;
  logic [AW-1:0]   wr_idx0;
  logic [AW-1:0]   wr_idx1;
  logic [AW:0]     n_wr;
  evt_t            head;

  assign used      = wr_ptr - rd_ptr;
  assign evt_valid = (wr_ptr != rd_ptr);
  assign pop       = evt_valid && evt_ready;

  // A same-cycle pop frees one slot for this cycle's pushes
  assign space     = DEPTH_W - SW'(used) + SW'(pop);
  assign need      = SW'(a_evt) + SW'(a1_evt);

  // Events fill slots in channel order; whatever does not fit is dropped
  assign slot0_en   = (a_evt || a1_evt) && (space != '0);
  assign slot1_en   = a_evt && a1_evt && (space >= SW'(2));
  assign drop       = (need > space);
  assign slot0_data = a_evt ? make_evt(CH_A, a_filt) : make_evt(CH_A1, a1_filt);
  assign slot1_data = make_evt(CH_A1, a1_filt);
  assign wr_idx0    = wr_ptr[AW-1:0];
  assign wr_idx1    = wr_idx0 + AW'(1);
  assign n_wr       = (AW+1)'(slot0_en) + (AW+1)'(slot1_en);

  always_ff @(posedge clk) begin
    if (slot0_en) mem[wr_idx0] <= slot0_data;
    if (slot1_en) mem[wr_idx1] <= slot1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + n_wr;
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign head     = mem[rd_ptr[AW-1:0]];
  assign evt_data = evt_valid ? head : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_gate_edge_monitor.sv
// ============================================================================
// tb_gate_edge_monitor -- sample-window model plus directed edge scenarios.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_gate_edge_monitor;

  localparam int S = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       a_in = 1'b0;
  logic       a1_in = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       a_filt;
  logic       a1_filt;
  logic       evt_valid;
  logic [1:0] evt_data;
  logic       ovf;

  int tests = 0;
  int fails = 0;

  gate_edge_monitor #(.STABLE_CYCLES(S), .FIFO_DEPTH(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .a1_in     (a1_in),
    .a_filt    (a_filt),
    .a1_filt   (a1_filt),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a level is accepted once the S+1 synchronized samples (raw samples
  // taken 2..S+2 edges ago) all disagree with the current filtered level.
  bit         mf [2];
  bit         sh [2][S+2];
  logic [1:0] q[$];
  logic [1:0] pev[$];
  bit         movf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        mf[c] = 1'b0;
        for (int k = 0; k < S+2; k++) sh[c][k] = 1'b0;
      end
      q.delete();
      pev.delete();
      movf = 1'b0;
    end else begin
      bit drop;
      bit tog [2];
      bit raw [2];
      drop = 1'b0;
      if (q.size() > 0 && evt_ready) void'(q.pop_front());
      foreach (pev[i]) begin
        if (q.size() < D) q.push_back(pev[i]);
        else drop = 1'b1;
      end
      pev.delete();
      if (drop)         movf = 1'b1;
      else if (ovf_clr) movf = 1'b0;
      raw[0] = a_in;
      raw[1] = a1_in;
      for (int c = 0; c < 2; c++) begin
        tog[c] = 1'b1;
        for (int k = 1; k <= S+1; k++) if (sh[c][k] == mf[c]) tog[c] = 1'b0;
        if (tog[c]) begin
          mf[c] = !mf[c];
          pev.push_back({c[0], mf[c]});
        end
        for (int k = S+1; k >= 1; k--) sh[c][k] = sh[c][k-1];
        sh[c][0] = raw[c];
      end
    end
  end

  always @(negedge clk) begin
    chk("m_a_filt", a_filt, mf[0]);
    chk("m_a1_filt", a1_filt, mf[1]);
    chk("m_evt_valid", evt_valid, q.size() > 0);
    chk("m_evt_data", evt_data, (q.size() > 0) ? q[0] : 2'b00);
    chk("m_ovf", ovf, movf);
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_evt_valid", evt_valid, 2'b00);
    chk("rst_a_filt", a_filt, 2'b00);
    chk("rst_a1_filt", a1_filt, 2'b00);
    chk("rst_evt_data", evt_data, 2'b00);
    chk("rst_ovf", ovf, 2'b00);
    a_in  = 1'b0;
    a1_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] exp4 [4];

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("init_evt_valid", evt_valid, 2'b00);
    chk("init_ovf", ovf, 2'b00);
    edges(2);
    rst_n = 1'b1;

    // Single rising edge on a: filt after 6 edges, event visible one later
    edges(1);
    a_in = 1'b1;
    edges(6);
    chk("t1_a_filt_e5", a_filt, 2'b00);
    edges(1);
    chk("t1_a_filt_e6", a_filt, 2'b01);
    chk("t1_valid_e6", evt_valid, 2'b00);
    edges(1);
    chk("t1_valid_e7", evt_valid, 2'b01);
    chk("t1_data_e7", evt_data, 2'b01);
    pop_one();
    chk("t1_empty", evt_valid, 2'b00);

    // Short pulses on a1 are rejected; a held level then takes exactly 6 edges
    a1_in = 1'b1;
    edges(1);
    a1_in = 1'b0;
    edges(10);
    a1_in = 1'b1;
    edges(3);
    a1_in = 1'b0;
    edges(10);
    chk("t2_a1_filt_glitch", a1_filt, 2'b00);
    chk("t2_no_evt", evt_valid, 2'b00);
    a1_in = 1'b1;
    edges(6);
    chk("t2_a1_filt_e5", a1_filt, 2'b00);
    edges(1);
    chk("t2_a1_filt_e6", a1_filt, 2'b01);
    edges(1);
    chk("t2_data", evt_data, 2'b11);
    pop_one();

    // Simultaneous rises: chan 0 ahead of chan 1
    pulse_reset();
    edges(1);
    a_in  = 1'b1;
    a1_in = 1'b1;
    edges(8);
    chk("t3_first", evt_data, 2'b01);
    pop_one();
    chk("t3_second", evt_data, 2'b11);
    pop_one();
    chk("t3_empty", evt_valid, 2'b00);

    // Six events into a four-deep FIFO with no consumer
    a_in = 1'b0; a1_in = 1'b0; edges(10);
    a_in = 1'b1; a1_in = 1'b1; edges(10);
    a_in = 1'b0; a1_in = 1'b0; edges(10);
    chk("t4_ovf_set", ovf, 2'b01);
    ovf_clr = 1'b1;
    edges(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", ovf, 2'b00);
    exp4 = '{2'b00, 2'b10, 2'b01, 2'b11};
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", evt_data, exp4[i]);
      pop_one();
    end
    chk("t4_empty", evt_valid, 2'b00);

    // Full FIFO, pop and two events in the same cycle
    a_in = 1'b1; a1_in = 1'b1; edges(10);
    a_in = 1'b0; a1_in = 1'b0; edges(10);
    chk("t5_full_no_ovf", ovf, 2'b00);
    a_in = 1'b1; a1_in = 1'b1;
    edges(7);
    evt_ready = 1'b1;
    edges(1);
    evt_ready = 1'b0;
    chk("t5_ovf", ovf, 2'b01);
    exp4 = '{2'b11, 2'b00, 2'b10, 2'b01};
    for (int i = 0; i < 4; i++) begin
      chk("t5_order", evt_data, exp4[i]);
      pop_one();
    end
    chk("t5_empty", evt_valid, 2'b00);
    ovf_clr = 1'b1;
    edges(1);
    ovf_clr = 1'b0;

    // Reset with three events queued and a filter pending
    a_in = 1'b0; a1_in = 1'b0; edges(10);
    a_in = 1'b1; edges(10);
    a1_in = 1'b1;
    edges(3);
    chk("t6_queued_valid", evt_valid, 2'b01);
    pulse_reset();
    edges(12);
    chk("t6_no_evt", evt_valid, 2'b00);
    chk("t6_a1_filt", a1_filt, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
